tlc_conflict_monitor: RTL



---
 rtl/tlc_conflict_monitor.sv | 113 +++++++++++
 1 files changed

// File: rtl/tlc_conflict_monitor.sv
// rtl/tlc_conflict_monitor.sv - traffic-light output watchdog with sticky fault and fail-safe red flash
// Checks encoding, mutual exclusion, sequence and timing of the two light codes every cycle.
module tlc_conflict_monitor #(
    parameter int MIN_YEL   = 3,
    parameter int MAX_FGRE  = 14,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    input  logic       clear_fault,
    output logic [2:0] safe_highway,
    output logic [2:0] safe_farm,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] viol_cnt
);
    localparam logic [2:0] C_G = 3'b001;
    localparam logic [2:0] C_Y = 3'b010;
    localparam logic [2:0] C_R = 3'b100;
    localparam int YW = $clog2(MIN_YEL + 1);
    localparam int FW = $clog2(MAX_FGRE + 1);
    localparam int DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [2:0]    prev_h, prev_f;
    logic          prev_valid;
    logic [YW-1:0] yel_h, yel_f;
    logic [FW-1:0] fgre_cnt;
    logic [DW-1:0] flash_div;
    logic          flash_phase;
    logic          v_code, v_conf, v_step, v_yel, v_fgre, any_viol;
    logic [2:0]    win_code;

    function automatic logic is_legal(input logic [2:0] c);
        return (c == C_G) || (c == C_Y) || (c == C_R);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == C_G && c == C_Y) || (p == C_Y && c == C_R) || (p == C_R && c == C_G);
    endfunction

    always_comb begin
        v_code = !is_legal(light_highway) || !is_legal(light_farm);
        v_conf = (light_highway != C_R) && (light_farm != C_R);
        v_step = prev_valid && is_legal(light_highway) && is_legal(light_farm)
                 && is_legal(prev_h) && is_legal(prev_f)
                 && !(step_ok(prev_h, light_highway) && step_ok(prev_f, light_farm));
        v_yel  = prev_valid
                 && ((prev_h == C_Y && light_highway == C_R && yel_h < YW'(MIN_YEL))
                  || (prev_f == C_Y && light_farm == C_R && yel_f < YW'(MIN_YEL)));
        v_fgre = (light_farm == C_G) && (fgre_cnt == FW'(MAX_FGRE));
        any_viol = v_code || v_conf || v_step || v_yel || v_fgre;
        win_code = 3'd0;
        if (v_code)      win_code = 3'd1;
        else if (v_conf) win_code = 3'd2;
        else if (v_step) win_code = 3'd3;
        else if (v_yel)  win_code = 3'd4;
        else if (v_fgre) win_code = 3'd5;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h      <= C_R;
            prev_f      <= C_R;
            prev_valid  <= 1'b0;
            yel_h       <= '0;
            yel_f       <= '0;
            fgre_cnt    <= '0;
            flash_div   <= '0;
            flash_phase <= 1'b1;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            viol_cnt    <= 8'd0;
        end else begin
            prev_h     <= light_highway;
            prev_f     <= light_farm;
            prev_valid <= 1'b1;
            yel_h    <= (light_highway != C_Y) ? '0 : (yel_h < YW'(MIN_YEL)) ? yel_h + 1'b1 : yel_h;
            yel_f    <= (light_farm != C_Y) ? '0 : (yel_f < YW'(MIN_YEL)) ? yel_f + 1'b1 : yel_f;
            fgre_cnt <= (light_farm != C_G) ? '0 : (fgre_cnt < FW'(MAX_FGRE)) ? fgre_cnt + 1'b1 : fgre_cnt;

            // A clear request loses to a violation in the same cycle, which reloads the code.
            if (any_viol) begin
                if (!fault || clear_fault) begin
                    fault      <= 1'b1;
                    fault_code <= win_code;
                end
            end else if (clear_fault) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
            end

            if (any_viol && viol_cnt != 8'hFF)
                viol_cnt <= viol_cnt + 8'd1;

            if (any_viol && !fault) begin
                flash_phase <= 1'b1;
                flash_div   <= '0;
            end else if (fault) begin
                if (flash_div == DW'(FLASH_DIV - 1)) begin
                    flash_div   <= '0;
                    flash_phase <= ~flash_phase;
                end else begin
                    flash_div <= flash_div + 1'b1;
                end
            end
        end
    end

    assign safe_highway = fault ? {flash_phase, 2'b00} : prev_h;
    assign safe_farm    = fault ? {flash_phase, 2'b00} : prev_f;
endmodule
